teller_dispatch: RTL and testbench

TELLER_DISPATCH -- requirements
Module: teller_dispatch

---
 rtl/td_pkg.sv | 20 ++
 rtl/rr_arbiter3.sv | 27 ++
 rtl/teller_dispatch.sv | 123 ++++++++++++
 tb/tb_teller_dispatch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/td_pkg.sv
// Shared types for the teller dispatcher: FSM states, teller count and
// teller index type.
package td_pkg;

  localparam int NTELLER = 3;

  typedef logic [1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALL   = 2'd1,
    SETTLE = 2'd2
  } td_state_e;

  // Next teller index, wrapping 2 -> 0.
  function automatic tid_t next_id(input tid_t i);
    return (i == tid_t'(2)) ? tid_t'(0) : i + tid_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational round-robin select over three requesters, searching from
// ptr upward with wrap-around.
module rr_arbiter3
  import td_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  tid_t cand;

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    cand      = (ptr == 2'd3) ? tid_t'(0) : ptr;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_valid && req[cand]) begin
        gnt_id    = cand;
        gnt_valid = 1'b1;
      end
      cand = next_id(cand);
    end
  end

endmodule

// File: rtl/teller_dispatch.sv
// Calls the next queued customer to a free teller window (round-robin).
// Define TD_NOSHOW_SKIP_EN to drop a no-show call with a skip pulse;
// otherwise a no-show keeps the same teller called indefinitely.
module teller_dispatch
  import td_pkg::*;
#(
  parameter int CALL_TIMEOUT = 15,
  parameter int NTELLER      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         pcount,
  input  logic               frontPC,
  input  logic [NTELLER-1:0] teller_en,
  input  logic [NTELLER-1:0] teller_done,
  output logic               call_valid,
  output logic [1:0]         call_id,
  output logic [NTELLER-1:0] busy,
  output logic [1:0]         tcount,
  output logic               skip
);

  localparam int CW = (CALL_TIMEOUT > 1) ? $clog2(CALL_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CALL_TIMEOUT - 1);

  td_state_e          state_q, state_d;
  logic               call_valid_q, call_valid_d;
  tid_t               call_id_q, call_id_d;
  logic [NTELLER-1:0] busy_q, busy_d;
  logic               skip_q, skip_d;
  tid_t               ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               front_prev_q, front_prev_d;

  logic arrival;
  tid_t gnt_id;
  logic gnt_valid;

  // frontPC is active-low: a 1 -> 0 transition is a customer leaving the head.
  assign arrival = front_prev_q & ~frontPC;

  rr_arbiter3 u_arb (
    .req       (teller_en & ~busy_q),
    .ptr       (ptr_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d      = state_q;
    call_valid_d = call_valid_q;
    call_id_d    = call_id_q;
    busy_d       = busy_q & ~teller_done;
    skip_d       = 1'b0;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    front_prev_d = frontPC;
    case (state_q)
      IDLE: begin
        if (pcount != 3'd0 && gnt_valid) begin
          state_d      = CALL;
          call_id_d    = gnt_id;
          call_valid_d = 1'b1;
          cnt_d        = '0;
        end
      end
      CALL: begin
        if (!teller_en[call_id_q]) begin
          state_d      = IDLE;
          call_valid_d = 1'b0;
        end else if (arrival) begin
          busy_d[call_id_q] = 1'b1;
          state_d           = SETTLE;
          call_valid_d      = 1'b0;
          ptr_d             = next_id(call_id_q);
        end else if (cnt_q == CNT_MAX) begin
`ifdef TD_NOSHOW_SKIP_EN
          skip_d       = 1'b1;
          state_d      = IDLE;
          call_valid_d = 1'b0;
          ptr_d        = next_id(call_id_q);
`else
          cnt_d        = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // One dead cycle so a stale pcount cannot trigger a second grant.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      call_valid_q <= 1'b0;
      call_id_q    <= '0;
      busy_q       <= '0;
      skip_q       <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      front_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      call_valid_q <= call_valid_d;
      call_id_q    <= call_id_d;
      busy_q       <= busy_d;
      skip_q       <= skip_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      front_prev_q <= front_prev_d;
    end
  end

  assign call_valid = call_valid_q;
  assign call_id    = call_id_q;
  assign busy       = busy_q;
  assign skip       = skip_q;
  assign tcount     = {1'b0, teller_en[0]} + {1'b0, teller_en[1]} + {1'b0, teller_en[2]};

endmodule

// File: tb/tb_teller_dispatch.sv
// Bench for teller_dispatch: directed scenarios then random traffic, each
// cycle compared against a behavioural model of the dispatch rules.
module tb_teller_dispatch;

  localparam int CALL_TIMEOUT = 15;

  logic       clk;
  logic       rst;
  logic [2:0] pcount;
  logic       frontPC;
  logic [2:0] teller_en;
  logic [2:0] teller_done;
  logic       call_valid;
  logic [1:0] call_id;
  logic [2:0] busy;
  logic [1:0] tcount;
  logic       skip;

  int n_checks = 0;
  int n_err    = 0;

  teller_dispatch #(.CALL_TIMEOUT(CALL_TIMEOUT), .NTELLER(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcount      (pcount),
    .frontPC     (frontPC),
    .teller_en   (teller_en),
    .teller_done (teller_done),
    .call_valid  (call_valid),
    .call_id     (call_id),
    .busy        (busy),
    .tcount      (tcount),
    .skip        (skip)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: who is being called, for how long, who is serving
  bit m_calling;
  bit m_settle;
  int m_id;
  int m_elapsed;
  int m_next;
  bit m_busy [3];
  bit m_skip;
  bit m_prev;

  task automatic model_step();
    bit arr;
    bit nb [3];
    arr = m_prev && (frontPC == 1'b0);
    if (rst) begin
      m_calling = 0; m_settle = 0; m_id = 0; m_elapsed = 0; m_next = 0;
      m_skip = 0; m_prev = 1;
      for (int i = 0; i < 3; i++) m_busy[i] = 0;
      return;
    end
    for (int i = 0; i < 3; i++) nb[i] = m_busy[i] && !teller_done[i];
    m_skip = 0;
    if (m_settle) begin
      m_settle = 0;
    end else if (m_calling) begin
      m_elapsed++;
      if (!teller_en[m_id]) begin
        m_calling = 0;
      end else if (arr) begin
        nb[m_id] = 1; m_calling = 0; m_settle = 1; m_next = (m_id + 1) % 3;
      end else if (m_elapsed == CALL_TIMEOUT) begin
`ifdef TD_NOSHOW_SKIP_EN
        m_skip = 1; m_calling = 0; m_next = (m_id + 1) % 3;
`else
        m_elapsed = 0;
`endif
      end
    end else if (pcount != 0) begin
      for (int k = 0; k < 3; k++) begin
        int t;
        t = (m_next + k) % 3;
        if (!m_calling && teller_en[t] && !m_busy[t]) begin
          m_calling = 1; m_id = t; m_elapsed = 0;
        end
      end
    end
    for (int i = 0; i < 3; i++) m_busy[i] = nb[i];
    m_prev = frontPC;
  endtask

  function automatic logic [7:0] m_busy_vec();
    return {5'b0, m_busy[2], m_busy[1], m_busy[0]};
  endfunction

  function automatic logic [7:0] en_count();
    int s = 0;
    for (int i = 0; i < 3; i++) s += int'(teller_en[i]);
    return 8'(s);
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  // driver: one clock, model update, then compare outputs
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("call_valid", {7'b0, call_valid}, {7'b0, m_calling});
    if (m_calling) chk("call_id", {6'b0, call_id}, 8'(m_id));
    chk("busy", {5'b0, busy}, m_busy_vec());
    chk("skip", {7'b0, skip}, {7'b0, m_skip});
    chk("tcount", {6'b0, tcount}, en_count());
    teller_done = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1; frontPC = 1'b1; teller_done = 3'b000;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic arrive();
    frontPC = 1'b0;
    cyc();
    frontPC = 1'b1;
  endtask

  task automatic wait_call(input int max_cyc, input string tag);
    int k = 0;
    while (call_valid !== 1'b1 && k < max_cyc) begin
      cyc();
      k++;
    end
    chk(tag, {7'b0, call_valid}, 8'd1);
  endtask

  initial begin
    bit saw_skip;
    bit held;
    int fall_rate;
    rst = 1'b1; pcount = 3'd0; frontPC = 1'b1; teller_en = 3'b000; teller_done = 3'b000;
    m_prev = 1;
    do_reset();
    chk("rst_call_valid", {7'b0, call_valid}, 8'd0);
    chk("rst_call_id", {6'b0, call_id}, 8'd0);
    chk("rst_busy", {5'b0, busy}, 8'd0);
    chk("rst_skip", {7'b0, skip}, 8'd0);

    // first call goes to teller 0, arrival makes it busy, next call to teller 1
    teller_en = 3'b111; pcount = 3'd2;
    wait_call(2, "s1_first_call");
    chk("s1_id0", {6'b0, call_id}, 8'd0);
    arrive();
    chk("s1_busy", {5'b0, busy}, 8'b001);
    wait_call(3, "s1_second_call");
    chk("s1_id1", {6'b0, call_id}, 8'd1);

    // called teller closes its window mid-call
    teller_en = 3'b101;
    cyc();
    chk("s4_abort_valid", {7'b0, call_valid}, 8'd0);
    chk("s4_abort_busy", {5'b0, busy}, 8'b001);
    chk("s4_abort_skip", {7'b0, skip}, 8'd0);

    // empty queue never calls
    do_reset();
    teller_en = 3'b111; pcount = 3'd0;
    held = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (call_valid !== 1'b0) held = 1'b1;
    end
    chk("s2_no_call", {7'b0, held}, 8'd0);

    // no-show
    do_reset();
    teller_en = 3'b111; pcount = 3'd1;
    wait_call(2, "s3_call");
    saw_skip = 1'b0; held = 1'b1;
    for (int i = 0; i < CALL_TIMEOUT + 1; i++) begin
      cyc();
      if (skip === 1'b1) saw_skip = 1'b1;
      if (call_valid !== 1'b1 || call_id !== 2'd0) held = 1'b0;
    end
`ifdef TD_NOSHOW_SKIP_EN
    chk("s3_skip_seen", {7'b0, saw_skip}, 8'd1);
`else
    chk("s3_skip_none", {7'b0, saw_skip}, 8'd0);
    chk("s3_call_held", {7'b0, held}, 8'd1);
`endif

    // same-cycle done on teller 0 and arrival for teller 2
    do_reset();
    teller_en = 3'b111; pcount = 3'd3;
    wait_call(2, "s5_call0");
    arrive();
    wait_call(3, "s5_call1");
    arrive();
    wait_call(3, "s5_call2");
    chk("s5_id2", {6'b0, call_id}, 8'd2);
    chk("s5_busy011", {5'b0, busy}, 8'b011);
    frontPC = 1'b0; teller_done = 3'b001;
    cyc();
    frontPC = 1'b1;
    chk("s5_busy110", {5'b0, busy}, 8'b110);

    // tcount and reset during a call
    teller_en = 3'b101;
    #1;
    chk("s6_tcount", {6'b0, tcount}, 8'd2);
    teller_en = 3'b111;
    wait_call(3, "s6_call");
    rst = 1'b1;
    cyc();
    chk("s6_rst_valid", {7'b0, call_valid}, 8'd0);
    chk("s6_rst_id", {6'b0, call_id}, 8'd0);
    chk("s6_rst_busy", {5'b0, busy}, 8'd0);
    chk("s6_rst_skip", {7'b0, skip}, 8'd0);
    rst = 1'b0;

    // random traffic; second half makes arrivals rare to reach timeouts
    for (int c = 0; c < 4000; c++) begin
      fall_rate = (c < 2000) ? 5 : 30;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) pcount = 3'($urandom_range(0, 7));
      if (frontPC == 1'b0) begin
        frontPC = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        teller_en = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, fall_rate) == 0) begin
        frontPC = 1'b0;
      end
      for (int i = 0; i < 3; i++) teller_done[i] = ($urandom_range(0, 11) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
